// File: rtl/game_sequencer_if.sv
// Board-side bundle for the breakout game sequencer.
// master drives buttons/status, slave is the sequencer.
interface game_sequencer_if;
    logic       btn_start;
    logic       btn_launch;
    logic       btn_pause;
    logic [1:0] mode_sel;
    logic       vsync;
    logic [9:0] ball_y;
    logic       win_in;
    logic [7:0] block_status1;
    logic [7:0] block_status2;
    logic [7:0] block_status3;
    logic       start;
    logic [1:0] mode;
    logic       ball_run;
    logic       ball_home;
    logic [1:0] lives;
    logic [7:0] score;
    logic [2:0] state;
    logic       game_won;
    logic       game_over;

    modport master (
        output btn_start, btn_launch, btn_pause, mode_sel, vsync,
        output ball_y, win_in, block_status1, block_status2, block_status3,
        input  start, mode, ball_run, ball_home, lives, score, state,
        input  game_won, game_over
    );

    modport slave (
        input  btn_start, btn_launch, btn_pause, mode_sel, vsync,
        input  ball_y, win_in, block_status1, block_status2, block_status3,
        output start, mode, ball_run, ball_home, lives, score, state,
        output game_won, game_over
    );
endinterface

// File: rtl/game_sequencer.sv
// Breakout game-flow FSM: serve, play, pause, miss handling,
// lives and score bookkeeping driven by frame ticks.
module game_sequencer #(
    parameter int unsigned LIVES        = 3,
    parameter logic [9:0]  BOTTOM_EDGE  = 10'd470,
    parameter int unsigned SERVE_FRAMES = 120,
    parameter int unsigned MISS_FRAMES  = 60
) (
    input logic             pxl_clk,
    input logic             reset,
    game_sequencer_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SERVE = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;
    localparam logic [2:0] S_MISS  = 3'd5;
    localparam logic [2:0] S_WON   = 3'd6;
    localparam logic [2:0] S_OVER  = 3'd7;

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] MISS_LAST  = 8'(MISS_FRAMES - 1);

    logic [2:0]  st;
    logic [2:0]  nxt;
    logic [7:0]  frame_cnt;
    logic        start_q;
    logic        launch_q;
    logic        pause_q;
    logic        vsync_q;
    logic [1:0]  mode_q;
    logic [1:0]  lives_q;
    logic [7:0]  score_q;
    logic [23:0] prev_status;
    logic [23:0] cur_status;
    logic [23:0] cleared;
    logic [4:0]  cleared_cnt;
    logic [8:0]  score_sum;
    logic [7:0]  score_next;

    logic start_rise;
    logic launch_rise;
    logic pause_rise;
    logic tick;
    logic miss;
    logic serve_done;
    logic miss_done;

    assign start_rise  = bus.btn_start & ~start_q;
    assign launch_rise = bus.btn_launch & ~launch_q;
    assign pause_rise  = bus.btn_pause & ~pause_q;
    assign tick        = bus.vsync & ~vsync_q;
    assign miss        = tick && (bus.ball_y >= BOTTOM_EDGE);
    assign serve_done  = tick && (frame_cnt == SERVE_LAST);
    assign miss_done   = tick && (frame_cnt == MISS_LAST);

    assign cur_status = {bus.block_status3, bus.block_status2,
                         bus.block_status1};
    assign cleared    = prev_status & ~cur_status;

    always_comb begin
        cleared_cnt = '0;
        for (int i = 0; i < 24; i++) begin
            cleared_cnt = cleared_cnt + 5'(cleared[i]);
        end
        score_sum  = {1'b0, score_q} + {4'b0, cleared_cnt};
        score_next = score_sum[8] ? 8'hff : score_sum[7:0];
    end

    // Win outranks a same-cycle miss so the last ball never costs a life.
    always_comb begin
        nxt = st;
        unique case (st)
            S_IDLE:  if (start_rise) nxt = S_LOAD;
            S_LOAD:  nxt = S_SERVE;
            S_SERVE: if (launch_rise || serve_done) nxt = S_PLAY;
            S_PLAY: begin
                if (bus.win_in)      nxt = S_WON;
                else if (miss)       nxt = S_MISS;
                else if (pause_rise) nxt = S_PAUSE;
            end
            S_PAUSE: if (pause_rise) nxt = S_PLAY;
            S_MISS: begin
                if (miss_done) nxt = (lives_q == 2'd0) ? S_OVER : S_SERVE;
            end
            S_WON:   if (start_rise) nxt = S_IDLE;
            S_OVER:  if (start_rise) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pxl_clk) begin
        if (reset) begin
            st          <= S_IDLE;
            frame_cnt   <= '0;
            start_q     <= 1'b0;
            launch_q    <= 1'b0;
            pause_q     <= 1'b0;
            vsync_q     <= 1'b0;
            mode_q      <= '0;
            lives_q     <= '0;
            score_q     <= '0;
            prev_status <= '0;
        end else begin
            start_q     <= bus.btn_start;
            launch_q    <= bus.btn_launch;
            pause_q     <= bus.btn_pause;
            vsync_q     <= bus.vsync;
            prev_status <= cur_status;
            st          <= nxt;
            if (nxt != st) begin
                frame_cnt <= '0;
            end else if (tick) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (st == S_IDLE && start_rise) begin
                mode_q  <= bus.mode_sel;
                lives_q <= 2'(LIVES);
            end else if (st == S_PLAY && nxt == S_MISS) begin
                lives_q <= lives_q - 2'd1;
            end
            if (st == S_IDLE && start_rise) begin
                score_q <= '0;
            end else if (st == S_PLAY || st == S_PAUSE) begin
                score_q <= score_next;
            end
        end
    end

    assign bus.state     = st;
    assign bus.mode      = mode_q;
    assign bus.lives     = lives_q;
    assign bus.score     = score_q;
    assign bus.start     = (st == S_LOAD);
    assign bus.ball_run  = (st == S_PLAY);
    assign bus.ball_home = (st == S_IDLE) || (st == S_LOAD) ||
                           (st == S_SERVE) || (st == S_WON) ||
                           (st == S_OVER);
    assign bus.game_won  = (st == S_WON);
    assign bus.game_over = (st == S_OVER);
endmodule

// File: tb/tb_game_sequencer.sv
// Directed-plus-random bench for game_sequencer with a
// score/lives reference kept as plain integers.
module tb_game_sequencer;
    logic pxl_clk = 1'b0;
    logic reset   = 1'b1;

    always #5 pxl_clk = ~pxl_clk;

    game_sequencer_if gif ();

    game_sequencer dut (
        .pxl_clk(pxl_clk),
        .reset  (reset),
        .bus    (gif)
    );

    localparam int ST_IDLE  = 0;
    localparam int ST_LOAD  = 1;
    localparam int ST_SERVE = 2;
    localparam int ST_PLAY  = 3;
    localparam int ST_PAUSE = 4;
    localparam int ST_MISS  = 5;
    localparam int ST_WON   = 6;
    localparam int ST_OVER  = 7;

    int tests = 0;
    int fails = 0;

    logic [23:0] field;
    int          exp_score;
    int          exp_lives;
    logic [1:0]  exp_mode;
    logic [23:0] nf;
    bit          saw_start;

    task automatic step();
        @(posedge pxl_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        gif.vsync = 1'b1;
        step();
        gif.vsync = 1'b0;
        step();
    endtask

    task automatic set_field(input logic [23:0] nv, input bit counts);
        int gained;
        gained = $countones(field & ~nv);
        if (counts) exp_score = (exp_score + gained > 255) ?
                                255 : exp_score + gained;
        field = nv;
        gif.block_status1 = field[7:0];
        gif.block_status2 = field[15:8];
        gif.block_status3 = field[23:16];
        step();
        chk("score", gif.score, exp_score);
    endtask

    task automatic press(input int b, input int exp_st);
        if (b == 0) gif.btn_start = 1'b1;
        if (b == 1) gif.btn_launch = 1'b1;
        if (b == 2) gif.btn_pause = 1'b1;
        step();
        chk("press_state", gif.state, exp_st);
        gif.btn_start  = 1'b0;
        gif.btn_launch = 1'b0;
        gif.btn_pause  = 1'b0;
        step();
    endtask

    task automatic miss_round();
        gif.ball_y = 10'd470 + 10'($urandom_range(0, 40));
        tick();
        exp_lives--;
        chk("miss_state", gif.state, ST_MISS);
        chk("miss_lives", gif.lives, exp_lives);
        chk("miss_run", gif.ball_run, 0);
        gif.ball_y = 10'd200;
        saw_start = 1'b0;
        repeat (59) begin
            tick();
            if (gif.start) saw_start = 1'b1;
        end
        chk("miss_hold", gif.state, ST_MISS);
        gif.vsync = 1'b1;
        step();
        chk("miss_exit", gif.state, exp_lives == 0 ? ST_OVER : ST_SERVE);
        if (gif.start) saw_start = 1'b1;
        gif.vsync = 1'b0;
        step();
        chk("miss_nostart", saw_start, 0);
        if (exp_lives != 0) press(1, ST_PLAY);
    endtask

    task automatic check_reset_values();
        chk("rst_state", gif.state, ST_IDLE);
        chk("rst_start", gif.start, 0);
        chk("rst_mode", gif.mode, 0);
        chk("rst_run", gif.ball_run, 0);
        chk("rst_home", gif.ball_home, 1);
        chk("rst_lives", gif.lives, 0);
        chk("rst_score", gif.score, 0);
        chk("rst_won", gif.game_won, 0);
        chk("rst_over", gif.game_over, 0);
    endtask

    initial begin
        gif.btn_start     = 1'b0;
        gif.btn_launch    = 1'b0;
        gif.btn_pause     = 1'b0;
        gif.mode_sel      = 2'b00;
        gif.vsync         = 1'b0;
        gif.ball_y        = 10'd200;
        gif.win_in        = 1'b0;
        gif.block_status1 = 8'h00;
        gif.block_status2 = 8'h00;
        gif.block_status3 = 8'h00;
        field     = '0;
        exp_score = 0;
        exp_lives = 0;
        exp_mode  = 2'b01;
        step();
        step();
        reset = 1'b0;
        step();
        check_reset_values();

        // game 1: start, auto-serve, scoring, pause, misses to OVER
        gif.mode_sel  = exp_mode;
        gif.btn_start = 1'b1;
        step();
        exp_lives = 3;
        chk("load_state", gif.state, ST_LOAD);
        chk("load_start", gif.start, 1);
        chk("load_mode", gif.mode, exp_mode);
        chk("load_lives", gif.lives, 3);
        chk("load_score", gif.score, 0);
        set_field(24'hffffff, 0);
        gif.btn_start = 1'b0;
        chk("serve_state", gif.state, ST_SERVE);
        chk("serve_start", gif.start, 0);
        chk("serve_home", gif.ball_home, 1);
        chk("serve_run", gif.ball_run, 0);

        repeat (119) tick();
        chk("serve_wait", gif.state, ST_SERVE);
        gif.vsync = 1'b1;
        step();
        chk("auto_launch", gif.state, ST_PLAY);
        chk("play_run", gif.ball_run, 1);
        chk("play_home", gif.ball_home, 0);
        gif.vsync = 1'b0;
        step();

        set_field(field & ~24'h000008, 1);
        repeat (3) step();
        set_field(field & ~24'h000020, 1);
        chk("score_two", gif.score, 2);
        set_field(24'hffffff, 1);
        chk("reload_keep", gif.score, 2);

        for (int i = 0; i < 6; i++) begin
            nf = field & ~(24'd1 << $urandom_range(0, 23));
            if (i == 5) nf = field & ~24'($urandom);
            set_field(nf, 1);
            repeat ($urandom_range(0, 3)) step();
        end

        press(2, ST_PAUSE);
        chk("pause_run", gif.ball_run, 0);
        chk("pause_home", gif.ball_home, 0);
        set_field(field & 24'h0f0f0f, 1);
        gif.win_in = 1'b1;
        step();
        chk("pause_win_ign", gif.state, ST_PAUSE);
        gif.win_in = 1'b0;
        step();
        press(2, ST_PLAY);

        gif.ball_y = 10'd469;
        tick();
        chk("edge_469", gif.state, ST_PLAY);
        gif.ball_y = 10'd470;
        tick();
        exp_lives--;
        chk("edge_470", gif.state, ST_MISS);
        chk("edge_lives", gif.lives, exp_lives);
        gif.ball_y = 10'd200;
        repeat (60) tick();
        chk("resrv", gif.state, ST_SERVE);
        press(1, ST_PLAY);
        miss_round();
        miss_round();
        chk("over_flag", gif.game_over, 1);
        chk("over_home", gif.ball_home, 1);
        chk("over_won", gif.game_won, 0);
        set_field(24'h000000, 0);

        gif.btn_start = 1'b1;
        repeat (5) step();
        chk("held_idle", gif.state, ST_IDLE);
        gif.btn_start = 1'b0;
        step();

        // game 2: manual launch, saturation, win beats miss
        exp_mode     = 2'($urandom_range(0, 3));
        gif.mode_sel = exp_mode;
        gif.btn_start = 1'b1;
        step();
        exp_score = 0;
        exp_lives = 3;
        chk("g2_load", gif.state, ST_LOAD);
        chk("g2_mode", gif.mode, exp_mode);
        chk("g2_lives", gif.lives, 3);
        gif.btn_start = 1'b0;
        set_field(24'hffffff, 0);
        repeat ($urandom_range(1, 4)) tick();
        press(1, ST_PLAY);
        for (int i = 0; i < 11; i++) begin
            set_field(24'h000000, 1);
            set_field(24'hffffff, 1);
        end
        chk("score_sat", gif.score, 255);
        gif.mode_sel = ~exp_mode;
        step();
        chk("mode_held", gif.mode, exp_mode);

        gif.win_in = 1'b1;
        gif.ball_y = 10'd480;
        gif.vsync  = 1'b1;
        step();
        chk("win_state", gif.state, ST_WON);
        chk("win_lives", gif.lives, exp_lives);
        gif.win_in = 1'b0;
        gif.ball_y = 10'd200;
        gif.vsync  = 1'b0;
        step();
        chk("won_flag", gif.game_won, 1);
        chk("won_run", gif.ball_run, 0);
        chk("won_home", gif.ball_home, 1);
        press(0, ST_IDLE);
        press(0, ST_LOAD);
        press(1, ST_PLAY);
        press(2, ST_PAUSE);
        chk("p2_run", gif.ball_run, 0);

        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_values();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game-flow controller for the breakout datapath.
- Latches the difficulty mode and issues the one-cycle start pulse that loads the block field in the collision logic.
- Holds the ball at the paddle until serve, runs, pauses and stops the ball, detects misses, and counts lives and score.
- Sits between the debounced board buttons and the ball/collision/render blocks; all timing is in pxl_clk cycles and frame ticks (vsync rising edges).

Parameters:
- LIVES, 3, lives loaded at game start (1..3).
- BOTTOM_EDGE, 10'd470, ball_y at or above this value is a miss.
- SERVE_FRAMES, 120, frame ticks in SERVE before the ball auto-launches.
- MISS_FRAMES, 60, frame ticks spent in MISS before re-serve or game over.

Ports:
- pxl_clk  in  1  pixel clock, sole clock.
- reset  in  1  synchronous, active-high reset.
- btn_start  in  1  debounced start button (level).
- btn_launch  in  1  debounced launch button (level).
- btn_pause  in  1  debounced pause button (level).
- mode_sel  in  2  board switches: bit0 = striped field, bit1 = single block, 00 = full field.
- vsync  in  1  VGA vsync level.
- ball_y  in  10  current ball row.
- win_in  in  1  win flag from collision logic.
- block_status1  in  8  row-1 block alive bits.
- block_status2  in  8  row-2 block alive bits.
- block_status3  in  8  row-3 block alive bits.
- start  out  1  one-cycle field-load pulse to collision logic.
- mode  out  2  latched mode, held stable for the whole game.
- ball_run  out  1  ball motion enable.
- ball_home  out  1  ball snapped to paddle.
- lives  out  2  remaining lives.
- score  out  8  blocks destroyed this game, saturating.
- state  out  3  current FSM state code.
- game_won  out  1  high in WON.
- game_over  out  1  high in OVER.

Behaviour:
- Reset: state=IDLE(0); start=0; mode=0; ball_run=0; ball_home=1; lives=0; score=0; frame counter=0; all edge and previous-status registers=0. Reset mid-game aborts immediately to IDLE and overrides all other events.
- Edge detect: buttons and vsync are registered once. A rise is current=1 and previous=0, 1-cycle latency. tick = vsync rise.
- Frame counter: 8 bits. Cleared on every state transition. Increments on tick. Never wraps before its compare is hit.
- IDLE(0): ball_home=1. On start rise: mode<=mode_sel, lives<=LIVES, score<=0, go to LOAD.
- LOAD(1): start=1 for exactly this one cycle. Next cycle go to SERVE unconditionally.
- SERVE(2): ball_home=1, ball_run=0. Go to PLAY on launch rise, or when the frame counter reaches SERVE_FRAMES (auto-launch). A launch rise in the same cycle as the timeout goes to PLAY once.
- PLAY(3): ball_run=1, ball_home=0. Transition priority, highest first:
  - win_in=1 goes to WON.
  - tick with ball_y>=BOTTOM_EDGE goes to MISS, and lives<=lives-1 in the same edge.
  - pause rise goes to PAUSE.
  - Win and miss in the same cycle resolve as WON, with no life lost.
- PAUSE(4): ball_run=0, ball_home=0. Pause rise goes to PLAY. A win_in rising while paused is ignored until PLAY resumes.
- MISS(5): ball_run=0. When the frame counter reaches MISS_FRAMES: lives==0 goes to OVER, otherwise go to SERVE. The block field is not reloaded (no start pulse).
- WON(6) and OVER(7): ball_run=0, ball_home=1, game_won or game_over=1. Start rise goes to IDLE. A second start rise is needed to begin a new game; a held button does not auto-restart.
- lives: a decrement never underflows, since MISS is entered only from lives>=1.
- Score source: prev_status (24 bits) is registered every cycle from {block_status3, block_status2, block_status1}. cleared = prev_status & ~current_status.
- Score update: in PLAY or PAUSE, score<=score+popcount(cleared), saturating at 255. Transitions 0->1, including the field reload after LOAD, never count. Score is frozen in all other states.
- Outputs are registered except start, ball_run, ball_home, game_won and game_over, which are Moore decodes of the state register.

Test Plan:
- Reset, then start rise with mode_sel=2'b01 -> state goes 0 to 1 to 2; start high exactly 1 cycle; mode=01; lives=3; score=0.
- In SERVE, no launch for 120 ticks -> PLAY entered on the 120th tick; ball_run=1; ball_home=0.
- In PLAY, clear block_status1 bit3, then bit5 several cycles later -> score=2. Reload all bits to 1 -> score stays 2.
- In PLAY, ball_y=475 on a tick -> MISS, lives 3 to 2. After 60 ticks -> SERVE, start stays 0. Repeat until lives=0 -> OVER, game_over=1.
- win_in and a miss tick in the same cycle -> WON, lives unchanged. Start rise -> IDLE; a second rise -> LOAD.
- Pause rise in PLAY -> PAUSE, ball_run=0. Assert reset for 1 cycle while paused -> IDLE with all outputs at reset values.
